// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and helpers for the dual-port-RAM FIFO.
//   FIFO_DEPTH_DEF / FIFO_WIDTH_DEF : default geometry
//   addr_w(depth)                   : RAM address width
//   fifo_ptr_t                      : pointer/count type for the default depth
//                                     (address bits plus one wrap bit)
package fifo_pkg;

  localparam int FIFO_DEPTH_DEF = 16;
  localparam int FIFO_WIDTH_DEF = 8;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  localparam int FIFO_AW_DEF = $clog2(FIFO_DEPTH_DEF);

  typedef logic [FIFO_AW_DEF:0] fifo_ptr_t;

endpackage

// File: rtl/fifo_using_dualport_ram.sv
// dual_port_ram: simple dual-port RAM, one write port and one read port.
//   wclk, we, waddr, wdata : synchronous write port
//   rclk, re, raddr, rdata : synchronous read port; rdata is registered and
//                            holds its value while re is low
// The storage is not reset.
module dual_port_ram
  import fifo_pkg::*;
#(
  parameter int depth = FIFO_DEPTH_DEF,
  parameter int width = FIFO_WIDTH_DEF,
  localparam int AW   = addr_w(depth)
) (
  input  logic             wclk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [width-1:0] wdata,
  input  logic             rclk,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [width-1:0] rdata
);

  logic [width-1:0] mem [depth];
  logic [width-1:0] rdata_q;

  always_ff @(posedge wclk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge rclk) begin
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fifo_using_dualport.sv
// fifo_using_dualport: single-clock FIFO over a simple dual-port RAM.
//   clk, rst (sync, active high)
//   wr_en, fifo_in            : producer side; accepted when !full
//   rd_en, fifo_out           : consumer side; accepted when !empty,
//                               fifo_out valid one cycle after acceptance
//   full, empty, almost_full, almost_empty : decoded from registered count
//   overflow, underflow       : sticky error flags, present only when
//                               FIFO_ERR_FLAGS_EN is defined
module fifo_using_dualport
  import fifo_pkg::*;
#(
  parameter int depth = FIFO_DEPTH_DEF,
  parameter int width = FIFO_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [width-1:0] fifo_in,
  output logic [width-1:0] fifo_out,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
`ifdef FIFO_ERR_FLAGS_EN
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow
`else
  output logic             almost_empty
`endif
);

  localparam int          AW    = addr_w(depth);
  localparam logic [AW:0] ONE   = (AW+1)'(1);
  localparam logic [AW:0] FULLC = (AW+1)'(depth);
  localparam logic [AW:0] AFC   = (AW+1)'(depth - 1);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             out_vld_q, out_vld_d;
  logic             wr_acc, rd_acc;
  logic [width-1:0] ram_rdata;

  // Flags decode only the registered count.
  assign full         = (count_q == FULLC);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AFC);
  assign almost_empty = (count_q <= ONE);

  // Gating with rst keeps the RAM and read register untouched during reset.
  assign wr_acc = wr_en && !full  && !rst;
  assign rd_acc = rd_en && !empty && !rst;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    out_vld_d = out_vld_q | rd_acc;
    if (wr_acc) wr_ptr_d = wr_ptr_q + ONE;
    if (rd_acc) rd_ptr_d = rd_ptr_q + ONE;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + ONE;
      2'b01:   count_d = count_q - ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      out_vld_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      out_vld_q <= out_vld_d;
    end
  end

  dual_port_ram #(.depth(depth), .width(width)) u_ram (
    .wclk  (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (fifo_in),
    .rclk  (clk),
    .re    (rd_acc),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (ram_rdata)
  );

  // The RAM read register has no reset; until the first accepted read after
  // reset the output is forced to zero instead.
  assign fifo_out = out_vld_q ? ram_rdata : '0;

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d, unf_q, unf_d;

  always_comb begin
    ovf_d = ovf_q | (wr_en && full);
    unf_d = unf_q | (rd_en && empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`endif

endmodule

// File: tb/tb_fifo_using_dualport.sv
// Directed bench for fifo_using_dualport: a vector table for reset, single
// word, streaming and reset-mid-operation, then hand sequences for fill,
// full/empty boundaries, pointer wrap and the optional error flags.
module tb_fifo_using_dualport;
  import fifo_pkg::*;

  localparam int D = 16;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, wr_en, rd_en;
  logic [W-1:0] fifo_in, fifo_out;
  logic         full, empty, almost_full, almost_empty;
`ifdef FIFO_ERR_FLAGS_EN
  logic         overflow, underflow;
`endif

  always #5 clk = ~clk;

  fifo_using_dualport #(.depth(D), .width(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .fifo_in      (fifo_in),
    .fifo_out     (fifo_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
`ifdef FIFO_ERR_FLAGS_EN
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
`else
    .almost_empty (almost_empty)
`endif
  );

  typedef struct {
    logic         rst, wr, rd;
    logic [W-1:0] din;
    logic [W-1:0] eout;
    logic [3:0]   eflags;  // {empty, almost_empty, almost_full, full}
  } vec_t;

  vec_t         vecs[$];
  logic [W-1:0] q[$];
  logic [W-1:0] last_out;
  int           pass_cnt = 0;
  int           total    = 0;

  function automatic logic [3:0] flags_of(input int c);
    return {c == 0, c <= 1, c >= D-1, c == D};
  endfunction

  function automatic vec_t mk(input logic r, w, rd, input logic [W-1:0] d,
                              input logic [W-1:0] eo, input int cnt);
    vec_t v;
    v.rst = r; v.wr = w; v.rd = rd; v.din = d; v.eout = eo;
    v.eflags = flags_of(cnt);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic step(input logic r, w, rd, input logic [W-1:0] d);
    @(negedge clk);
    rst = r; wr_en = w; rd_en = rd; fifo_in = d;
    @(posedge clk);
    #1;
  endtask

  // Queue model for the hand sequences: decides acceptance from the
  // pre-edge occupancy and checks data and flags after the edge.
  task automatic mstep(input string nm, input logic w, rd, input logic [W-1:0] d);
    logic wa, ra;
    wa = w  && (q.size() < D);
    ra = rd && (q.size() > 0);
    if (ra) last_out = q.pop_front();
    if (wa) q.push_back(d);
    step(1'b0, w, rd, d);
    chk({nm, "_data"}, 32'(fifo_out), 32'(last_out));
    chk({nm, "_flags"}, 32'({empty, almost_empty, almost_full, full}),
        32'(flags_of(q.size())));
  endtask

  initial begin
    logic [W-1:0] seq [7];
    seq = '{8'h34, 8'h24, 8'h31, 8'h22, 8'h35, 8'h12, 8'h27};
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; fifo_in = '0;

    // reset, single word, rejected read on empty
    vecs.push_back(mk(1, 0, 0, 8'h00, 8'h00, 0));
    vecs.push_back(mk(1, 0, 0, 8'h00, 8'h00, 0));
    vecs.push_back(mk(0, 1, 0, 8'h06, 8'h00, 1));
    vecs.push_back(mk(0, 0, 1, 8'h00, 8'h06, 0));
    vecs.push_back(mk(0, 0, 1, 8'h00, 8'h06, 0));
    // streaming at count 2
    vecs.push_back(mk(0, 1, 0, 8'h06, 8'h06, 1));
    vecs.push_back(mk(0, 1, 0, 8'h06, 8'h06, 2));
    for (int k = 0; k < 14; k++)
      vecs.push_back(mk(0, 1, 1, seq[k/2], (k < 2) ? 8'h06 : seq[(k-2)/2], 2));
    vecs.push_back(mk(0, 0, 1, 8'h00, 8'h27, 1));
    vecs.push_back(mk(0, 0, 1, 8'h00, 8'h27, 0));
    // reset mid-operation discards the stored word and clears fifo_out
    vecs.push_back(mk(0, 1, 0, 8'h55, 8'h27, 1));
    vecs.push_back(mk(1, 0, 0, 8'h00, 8'h00, 0));

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].din);
      chk($sformatf("vec%0d_data", i), 32'(fifo_out), 32'(vecs[i].eout));
      chk($sformatf("vec%0d_flags", i),
          32'({empty, almost_empty, almost_full, full}), 32'(vecs[i].eflags));
    end

    q.delete();
    last_out = 8'h00;

`ifdef FIFO_ERR_FLAGS_EN
    chk("errflags_after_rst", 32'({overflow, underflow}), 32'(2'b00));
`endif

    // fill to full, then a dropped write
    for (int i = 0; i < D; i++) mstep($sformatf("fill%0d", i), 1'b1, 1'b0, W'(8'hA0 + i));
    mstep("wr_when_full", 1'b1, 1'b0, 8'hEE);
`ifdef FIFO_ERR_FLAGS_EN
    chk("overflow_set", 32'(overflow), 32'(1));
`endif
    // both requests while full: only the read is taken, count -> 15
    mstep("rdwr_when_full", 1'b1, 1'b1, 8'hBB);
    for (int i = 0; i < D-1; i++) mstep($sformatf("drain%0d", i), 1'b0, 1'b1, 8'h00);

    // 20 writes and 20 reads interleaved so both pointers wrap
    for (int i = 0; i < 3; i++)  mstep($sformatf("wrap_pre%0d", i), 1'b1, 1'b0, W'(8'h40 + i));
    for (int i = 3; i < 20; i++) mstep($sformatf("wrap%0d", i), 1'b1, 1'b1, W'(8'h40 + i));
    for (int i = 0; i < 3; i++)  mstep($sformatf("wrap_post%0d", i), 1'b0, 1'b1, 8'h00);

    // both requests while empty: write only, fifo_out holds
    mstep("rdwr_when_empty", 1'b1, 1'b1, 8'h77);
    mstep("rd_last", 1'b0, 1'b1, 8'h00);
    // read on empty: fifo_out holds
    mstep("rd_when_empty", 1'b0, 1'b1, 8'h00);
`ifdef FIFO_ERR_FLAGS_EN
    chk("underflow_set", 32'(underflow), 32'(1));
    step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("errflags_cleared", 32'({overflow, underflow}), 32'(2'b00));
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
